alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 158 +++++++++++++++
 tb/tb_alu_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin front end that lets two 4-phase requesters share one combinational ALU.
// A transaction latches the winner's operands, waits out mul/div latency, captures the result, then holds ack until req drops.

`ifndef OP_AND
`define OP_AND    6'd0
`define OP_OR     6'd1
`define OP_ADD    6'd2
`define OP_XOR    6'd3
`define OP_SUB    6'd6
`define OP_SLT    6'd7
`define OP_MULT   6'd8
`define OP_DIV    6'd9
`define OP_REMDER 6'd10
`define OP_NOR    6'd12
`endif

module alu_arbiter #(
    parameter int unsigned MULDIV_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [5:0]  op0,
    input  logic [5:0]  op1,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [5:0]  alu_ctrl,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_ovf,
    input  logic        alu_cout,
    input  logic        alu_neg,
    output logic [31:0] result,
    output logic        zero,
    output logic        overflow,
    output logic        carry,
    output logic        negative,
    output logic        busy,
    output logic        grant
);

    localparam int CW = (MULDIV_WAIT > 0) ? $clog2(MULDIV_WAIT + 1) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, ACK} state_t;

    state_t        state, next_state;
    logic [CW-1:0] cnt;
    logic          last;
    logic          ack_on;

    logic          winner;
    logic          req_g;
    logic          is_muldiv;
    logic [5:0]    win_op;
    logic [31:0]   win_a, win_b;

    logic          do_latch, do_dec, do_capture, do_ack_set, do_ack_clr;

    // On a tie the requester not served last wins; a lone requester always wins.
    assign winner    = (req0 && req1) ? ~last : req1;
    assign win_op    = winner ? op1 : op0;
    assign win_a     = winner ? a1  : a0;
    assign win_b     = winner ? b1  : b0;
    assign is_muldiv = (win_op == `OP_MULT) || (win_op == `OP_DIV) || (win_op == `OP_REMDER);
    assign req_g     = grant ? req1 : req0;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        do_latch   = 1'b0;
        do_dec     = 1'b0;
        do_capture = 1'b0;
        do_ack_set = 1'b0;
        do_ack_clr = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    do_latch   = 1'b1;
                    next_state = EXEC;
                end
            end
            EXEC: begin
                if (cnt != '0) begin
                    do_dec = 1'b1;
                end else begin
                    do_capture = 1'b1;
                    next_state = ACK;
                end
            end
            ACK: begin
                // Ack is raised on the first ACK edge regardless of req, so an early drop still sees one ack cycle.
                if (!ack_on) begin
                    do_ack_set = 1'b1;
                end else if (!req_g) begin
                    do_ack_clr = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            last     <= 1'b1;
            grant    <= 1'b0;
            ack_on   <= 1'b0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_ctrl <= '0;
            result   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            carry    <= 1'b0;
            negative <= 1'b0;
        end else begin
            if (do_latch) begin
                grant    <= winner;
                alu_a    <= win_a;
                alu_b    <= win_b;
                alu_ctrl <= win_op;
                cnt      <= is_muldiv ? CW'(MULDIV_WAIT) : '0;
            end
            if (do_dec) cnt <= cnt - CW'(1);
            if (do_capture) begin
                result   <= alu_result;
                zero     <= alu_zero;
                overflow <= alu_ovf;
                carry    <= alu_cout;
                negative <= alu_neg;
            end
            if (do_ack_set) ack_on <= 1'b1;
            if (do_ack_clr) begin
                ack_on <= 1'b0;
                last   <= grant;
            end
        end
    end

    assign busy = (state != IDLE);
    assign ack0 = ack_on & ~grant;
    assign ack1 = ack_on & grant;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural ALU drives the shared port; directed and random transactions are checked
// against a transaction-level model (round-robin winner, fixed latency, expected result and flags).

`ifndef OP_AND
`define OP_AND    6'd0
`define OP_OR     6'd1
`define OP_ADD    6'd2
`define OP_XOR    6'd3
`define OP_SUB    6'd6
`define OP_SLT    6'd7
`define OP_MULT   6'd8
`define OP_DIV    6'd9
`define OP_REMDER 6'd10
`define OP_NOR    6'd12
`endif

module tb_alu_arbiter;

    localparam int W = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0, req1;
    logic [5:0]  op0, op1;
    logic [31:0] a0, b0, a1, b1;
    logic        ack0, ack1;
    logic [31:0] alu_a, alu_b;
    logic [5:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_zero, alu_ovf, alu_cout, alu_neg;
    logic [31:0] result;
    logic        zero, overflow, carry, negative, busy, grant;

    int   n_vec = 0;
    int   n_bad = 0;
    logic last_served;

    alu_arbiter #(.MULDIV_WAIT(W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
        .alu_cout(alu_cout), .alu_neg(alu_neg),
        .result(result), .zero(zero), .overflow(overflow), .carry(carry), .negative(negative),
        .busy(busy), .grant(grant)
    );

    always #5 clk = ~clk;

    // Returns {neg, carry, ovf, zero, result[31:0]}.
    function automatic logic [35:0] alu_fn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic        v, c;
        r = '0; v = 1'b0; c = 1'b0; s = '0;
        case (op)
            `OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0]; c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            `OP_SUB: begin
                s = {1'b0, a} - {1'b0, b};
                r = s[31:0]; c = s[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            `OP_AND:    r = a & b;
            `OP_OR:     r = a | b;
            `OP_XOR:    r = a ^ b;
            `OP_NOR:    r = ~(a | b);
            `OP_SLT:    r = {31'b0, ($signed(a) < $signed(b))};
            `OP_MULT:   r = a * b;
            `OP_DIV:    r = (b != 0) ? a / b : 32'd0;
            `OP_REMDER: r = (b != 0) ? a % b : 32'd0;
            default:    r = '0;
        endcase
        return {r[31], c, v, (r == 32'd0), r};
    endfunction

    function automatic bit is_md(input logic [5:0] op);
        return (op == `OP_MULT) || (op == `OP_DIV) || (op == `OP_REMDER);
    endfunction

    logic [35:0] alu_out;
    assign alu_out    = alu_fn(alu_ctrl, alu_a, alu_b);
    assign alu_result = alu_out[31:0];
    assign alu_zero   = alu_out[32];
    assign alu_ovf    = alu_out[33];
    assign alu_cout   = alu_out[34];
    assign alu_neg    = alu_out[35];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        last_served = 1'b1;
    endtask

    // Waits for ack[who], checks latency/result/flags/grant, then drops req[who] and checks the return to IDLE.
    // Expected ticks = 1 (to reach the sampling edge) + 2 edges + W for mul/div/rem.
    task automatic serve(input logic who, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int elapsed);
        logic [35:0] e;
        int          lat;
        int          exp_lat;
        logic        got;
        e       = alu_fn(op, a, b);
        exp_lat = 3 + (is_md(op) ? W : 0);
        lat     = elapsed;
        got     = 1'b0;
        while (!got && lat < 60) begin
            tick();
            lat++;
            n_vec++;
            if ((who ? ack0 : ack1) !== 1'b0) begin
                n_bad++;
                $display("FAIL other_ack: requester %0d acked while serving %0d", !who, who);
            end
            got = who ? ack1 : ack0;
        end
        n_vec++;
        if (lat != exp_lat) begin
            n_bad++;
            $display("FAIL latency req%0d op=%0d: got %0d ticks, want %0d", who, op, lat, exp_lat);
        end
        n_vec++;
        if (result !== e[31:0]) begin
            n_bad++;
            $display("FAIL result req%0d op=%0d a=%h b=%h: got %h want %h", who, op, a, b, result, e[31:0]);
        end
        n_vec++;
        if ({negative, carry, overflow, zero} !== e[35:32]) begin
            n_bad++;
            $display("FAIL flags nczv req%0d: got %b want %b", who, {negative, carry, overflow, zero}, e[35:32]);
        end
        n_vec++;
        if (grant !== who || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL grant_busy: got grant=%b busy=%b want grant=%b busy=1", grant, busy, who);
        end
        if (who) req1 = 1'b0;
        else     req0 = 1'b0;
        tick();
        n_vec++;
        if ({ack0, ack1, busy} !== 3'b000 || grant !== who) begin
            n_bad++;
            $display("FAIL release: got ack0=%b ack1=%b busy=%b grant=%b want 0 0 0 %b", ack0, ack1, busy, grant, who);
        end
        n_vec++;
        if (alu_a !== a || alu_b !== b || alu_ctrl !== op) begin
            n_bad++;
            $display("FAIL idle_hold: got %h %h %0d want %h %h %0d", alu_a, alu_b, alu_ctrl, a, b, op);
        end
        last_served = who;
    endtask

    task automatic test_reset;
        tick();
        n_vec++;
        if ({ack0, ack1, busy, grant, zero, overflow, carry, negative} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {ack0, ack1, busy, grant, zero, overflow, carry, negative});
        end
        n_vec++;
        if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_ctrl !== 6'd0 || result !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_data: got %h %h %h %h want all zero", alu_a, alu_b, alu_ctrl, result);
        end
        rst = 1'b0;
        last_served = 1'b1;
    endtask

    task automatic test_single_add;
        op0 = `OP_ADD; a0 = 32'd5; b0 = 32'd7; req0 = 1'b1;
        serve(1'b0, `OP_ADD, 32'd5, 32'd7, 0);
        n_vec++;
        if (result !== 32'd12 || zero !== 1'b0) begin
            n_bad++;
            $display("FAIL add_5_7 hold: got %0d zero=%b want 12 zero=0", result, zero);
        end
    endtask

    task automatic test_tie;
        do_reset();
        op0 = `OP_ADD; a0 = 32'd10; b0 = 32'd20;
        op1 = `OP_SUB; a1 = 32'd3;  b1 = 32'd3;
        req0 = 1'b1; req1 = 1'b1;
        serve(1'b0, `OP_ADD, 32'd10, 32'd20, 0);
        serve(1'b1, `OP_SUB, 32'd3, 32'd3, 0);
        n_vec++;
        if (result !== 32'd0 || zero !== 1'b1) begin
            n_bad++;
            $display("FAIL sub_3_3: got %0d zero=%b want 0 zero=1", result, zero);
        end
        req0 = 1'b1; req1 = 1'b1;
        serve(1'b0, `OP_ADD, 32'd10, 32'd20, 0);
        serve(1'b1, `OP_SUB, 32'd3, 32'd3, 0);
    endtask

    task automatic test_mult;
        op1 = `OP_MULT; a1 = 32'd6; b1 = 32'd7; req1 = 1'b1;
        tick();
        a1 = 32'd99;
        tick();
        n_vec++;
        if (alu_a !== 32'd6) begin
            n_bad++;
            $display("FAIL exec_isolation: got alu_a=%0d want 6", alu_a);
        end
        serve(1'b1, `OP_MULT, 32'd6, 32'd7, 2);
        n_vec++;
        if (result !== 32'd42) begin
            n_bad++;
            $display("FAIL mult_6_7: got %0d want 42", result);
        end
    endtask

    task automatic test_overflow;
        op0 = `OP_ADD; a0 = 32'h7FFF_FFFF; b0 = 32'd1; req0 = 1'b1;
        serve(1'b0, `OP_ADD, 32'h7FFF_FFFF, 32'd1, 0);
        n_vec++;
        if (result !== 32'h8000_0000 || {overflow, negative, carry} !== 3'b110) begin
            n_bad++;
            $display("FAIL add_overflow: got %h ovf/neg/c=%b want 80000000 110", result, {overflow, negative, carry});
        end
    endtask

    task automatic test_reset_mid_exec;
        op0 = `OP_MULT; a0 = 32'd11; b0 = 32'd3; req0 = 1'b1;
        tick();
        tick();
        n_vec++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset_busy: got %b want 1", busy);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({ack0, ack1, busy, grant} !== 4'b0000 || alu_a !== 32'd0 || alu_ctrl !== 6'd0 || result !== 32'd0) begin
            n_bad++;
            $display("FAIL async_reset: got ack/busy/grant=%b alu_a=%h ctrl=%0d result=%h want all zero",
                     {ack0, ack1, busy, grant}, alu_a, alu_ctrl, result);
        end
        tick();
        n_vec++;
        if ({ack0, ack1} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_no_ack: got %b want 00", {ack0, ack1});
        end
        rst = 1'b0;
        last_served = 1'b1;
        serve(1'b0, `OP_MULT, 32'd11, 32'd3, 0);
    endtask

    task automatic test_drop_early;
        int lat;
        op0 = `OP_MULT; a0 = 32'd9; b0 = 32'd5; req0 = 1'b1;
        op1 = `OP_ADD;  a1 = 32'd1; b1 = 32'd2;
        tick();
        req0 = 1'b0;
        req1 = 1'b1;
        lat = 1;
        while (!ack0 && lat < 60) begin
            tick();
            lat++;
            n_vec++;
            if (ack1 !== 1'b0) begin
                n_bad++;
                $display("FAIL drop_hold_off: ack1 high while req0 in flight");
            end
        end
        n_vec++;
        if (lat != 3 + W || result !== 32'd45) begin
            n_bad++;
            $display("FAIL drop_complete: got %0d ticks result %0d want %0d ticks result 45", lat, result, 3 + W);
        end
        tick();
        n_vec++;
        if ({ack0, ack1, busy} !== 3'b000) begin
            n_bad++;
            $display("FAIL drop_one_cycle: got ack0/ack1/busy=%b want 000", {ack0, ack1, busy});
        end
        last_served = 1'b0;
        serve(1'b1, `OP_ADD, 32'd1, 32'd2, 0);
    endtask

    function automatic logic [5:0] pick_op;
        case ($urandom_range(0, 9))
            0: return `OP_AND;
            1: return `OP_OR;
            2: return `OP_ADD;
            3: return `OP_XOR;
            4: return `OP_SUB;
            5: return `OP_SLT;
            6: return `OP_MULT;
            7: return `OP_DIV;
            8: return `OP_REMDER;
            default: return `OP_NOR;
        endcase
    endfunction

    function automatic logic [31:0] pick_val;
        if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 15));
        return $urandom();
    endfunction

    task automatic test_random;
        logic [1:0] pat;
        logic       w;
        for (int it = 0; it < 30; it++) begin
            pat = 2'($urandom_range(1, 3));
            op0 = pick_op(); a0 = pick_val(); b0 = pick_val();
            op1 = pick_op(); a1 = pick_val(); b1 = pick_val();
            req0 = pat[0];
            req1 = pat[1];
            while (req0 || req1) begin
                w = (req0 && req1) ? ~last_served : req1;
                serve(w, w ? op1 : op0, w ? a1 : a0, w ? b1 : b0, 0);
            end
        end
    endtask

    initial begin
        req0 = 1'b0; req1 = 1'b0;
        op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        last_served = 1'b1;
        test_reset();
        test_single_add();
        test_tie();
        test_mult();
        test_overflow();
        test_reset_mid_exec();
        test_drop_early();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
